// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e state_q, state_d;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   ma_q, mb_q, a_orig_q;
  logic               sa_q, sb_q, bz_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  logic               accept;
  logic [WIDTH-1:0]   start_ma, start_mb;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_dbz;

  assign accept = start && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: begin
        if (flush) state_d = StIdle;
        else if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_ma = (op[0] && a[WIDTH-1]) ? -a : a;
    start_mb = (op[0] && b[WIDTH-1]) ? -b : b;

    // Multiplier sits in the low half and shifts out as the product shifts in.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // Top bit of the difference doubles as the borrow: clear means shift >= divisor.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mb_q};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_acc   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};

    prod  = (op_q[0] && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo_s = (op_q[0] && (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s = (op_q[0] && sa_q) ? -rem_q : rem_q;

    fix_hi  = prod[2*WIDTH-1:WIDTH];
    fix_lo  = prod[WIDTH-1:0];
    fix_dbz = 1'b0;
    if (op_q[1]) begin
      if (bz_q) begin
        fix_hi  = a_orig_q;
        fix_lo  = '1;
        fix_dbz = 1'b1;
      end else begin
        fix_hi = rem_s;
        fix_lo = quo_s;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      a_orig_q <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (wr_hi) hi_q <= wdata;
          if (wr_lo) lo_q <= wdata;
          if (accept) begin
            op_q     <= op;
            ma_q     <= start_ma;
            mb_q     <= start_mb;
            a_orig_q <= a;
            sa_q     <= a[WIDTH-1];
            sb_q     <= b[WIDTH-1];
            bz_q     <= (b == '0);
            cnt_q    <= '0;
            rem_q    <= '0;
            acc_q    <= {{WIDTH{1'b0}}, (op[1] ? start_ma : start_mb)};
          end
        end
        StCalc: begin
          if (!flush) begin
            cnt_q <= cnt_q + CntW'(1);
            if (op_q[1]) begin
              acc_q <= div_acc;
              rem_q <= div_rem;
            end else begin
              acc_q <= mul_acc;
            end
          end
        end
        StFix: begin
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            dbz_q  <= fix_dbz;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter against a plain-arithmetic reference model.
module tb_mdu_iter;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, flush, wr_hi, wr_lo;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int vectors = 0;
  int miscompares = 0;
  int edges, busy_cnt, dcount;

  logic [W-1:0] exp_hi, exp_lo, pend_hi, pend_lo;
  logic         exp_dbz, pend_dbz;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference results from the arithmetic definition of each operation.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    pend_dbz = 1'b0;
    case (o)
      2'b00: p = {32'b0, x} * {32'b0, y};
      2'b01: p = sx * sy;
      default: p = '0;
    endcase
    if (!o[1]) begin
      pend_hi = p[63:32];
      pend_lo = p[31:0];
    end else if (y == 0) begin
      pend_hi  = x;
      pend_lo  = '1;
      pend_dbz = 1'b1;
    end else if (o == 2'b10) begin
      pend_hi = x % y;
      pend_lo = x / y;
    end else begin
      q = sx / sy;
      r = sx % sy;
      pend_hi = r[31:0];
      pend_lo = q[31:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
    if (busy) busy_cnt++;
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    model(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    check("busy_after_start", busy, 1'b1);
    check("done_low_after_start", done, 1'b0);
  endtask

  task automatic finish(input string tag);
    while (!done && edges < 60) tick();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency"}, edges, 33);
    check({tag, "_busy_cycles"}, busy_cnt, 33);
    check({tag, "_busy_clear"}, busy, 1'b0);
    check({tag, "_hi"}, hi, pend_hi);
    check({tag, "_lo"}, lo, pend_lo);
    check({tag, "_dbz"}, div_by_zero, pend_dbz);
    exp_hi = pend_hi; exp_lo = pend_lo; exp_dbz = pend_dbz;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_dbz"}, div_by_zero, exp_dbz);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_held("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish("multu_max");

    launch(2'b01, -32'sd3, 32'd7);
    finish("mult_neg");
    launch(2'b11, -32'sd7, 32'd2);
    finish("div_b2b");

    launch(2'b10, 32'd5, 32'd0);
    finish("divu_zero");
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    finish("div_ovf");
    launch(2'b11, 32'hFFFF_FFF0, 32'd0);
    finish("div_zero_signed");

    for (int i = 0; i < 12; i++) begin
      logic [1:0] o;
      logic [W-1:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 3) == 0) x = -$urandom_range(0, 50);
      launch(o, x, y);
      finish("rand");
    end

    // Flush mid-CALC: nothing retires.
    launch(2'b10, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_held("flush_calc");
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    check("flush_calc_no_done", dcount, 0);

    // Flush in the FIX cycle also cancels.
    launch(2'b00, 32'd1234, 32'd5678);
    repeat (32) tick();
    check("fix_still_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_held("flush_fix");

    // start with flush in IDLE is suppressed.
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check_held("start_flush");
    tick();
    check_held("start_flush_later");

    // MTHI while idle.
    wr_hi = 1'b1; wdata = 32'h1234_5678;
    tick();
    wr_hi = 1'b0;
    exp_hi = 32'h1234_5678;
    check_held("mthi");

    // MTLO while busy is ignored.
    launch(2'b10, 32'd1000, 32'd3);
    wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    wr_lo = 1'b0;
    check("mtlo_busy_lo", lo, exp_lo);
    check("mtlo_busy_hi", hi, exp_hi);
    finish("after_mtlo_busy");

    // MTLO together with start: write lands, then FIX overwrites.
    wr_lo = 1'b1; wdata = 32'hCAFE_F00D;
    launch(2'b01, 32'h0001_0000, 32'hFFFF_0000);
    check("start_mtlo_lo", lo, 32'hCAFE_F00D);
    finish("start_mtlo");

    // Asynchronous reset between edges.
    launch(2'b11, 32'd999, 32'd13);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    check_held("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    launch(2'b11, -32'sd100, 32'd7);
    finish("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO result registers. It sits beside the EX stage of the five-stage pipeline and extends the core beyond single-cycle ALU operations to MULT/MULTU/DIV/DIVU, plus MTHI/MTLO writes. Each operation takes a multi-cycle start/busy/done handshake. `busy` feeds the hazard unit as a stall source, and `flush` lets the control-hazard logic cancel an operation launched down a mispredicted path.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Must be even and ≥ 8.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `op` input 2: operation select. 00 = multu, 01 = mult, 10 = divu, 11 = div.
- `a` input WIDTH: multiplicand / dividend.
- `b` input WIDTH: multiplier / divisor.
- `flush` input 1: cancel the in-flight operation, or suppress `start`.
- `wr_hi` input 1: write `wdata` to HI (MTHI).
- `wr_lo` input 1: write `wdata` to LO (MTLO).
- `wdata` input WIDTH: write data for `wr_hi` / `wr_lo`.
- `busy` output 1: operation in progress. Registered.
- `done` output 1: one-cycle pulse when HI/LO have been updated by an operation. Registered.
- `hi` output WIDTH: HI register. Product upper half, or remainder.
- `lo` output WIDTH: LO register. Product lower half, or quotient.
- `div_by_zero` output 1: set with `done` when the last division had `b == 0`. Held until the next `done`.

## Operation
- **Reset** (asynchronous, active-high):
  - State goes to IDLE.
  - `busy`, `done`, `div_by_zero` = 0.
  - `hi`, `lo` = 0.
  - Internal counter and working registers = 0.
- **States and transitions:**
  - IDLE → CALC on `start & !flush`.
  - CALC → CALC while counter < WIDTH−1.
  - CALC → FIX when counter == WIDTH−1.
  - FIX → IDLE on the next edge.
  - CALC or FIX → IDLE on any edge with `flush == 1`.
- **Start (IDLE):**
  - Latch `op`.
  - Latch |a| and |b|: two's-complement magnitude for signed ops, raw value for unsigned ops.
  - Latch sign(a), sign(b), the original `a`, and a `b == 0` flag.
  - Clear the counter.
- **Multiply (CALC):**
  - Shift-add, one multiplier bit per cycle.
  - Uses a 2·WIDTH-bit accumulator.
- **Divide (CALC):**
  - Restoring division, one quotient bit per cycle.
  - Uses a WIDTH+1-bit partial remainder.
- **FIX (final edge):**
  - Apply sign correction. Signed product is negated if sign(a)≠sign(b).
  - Signed quotient is negated if sign(a)≠sign(b), truncating toward zero.
  - Signed remainder takes sign(a).
  - Write `hi`/`lo`, pulse `done`, and update `div_by_zero`.
  - `div_by_zero` is always 0 after a multiply.
- **Divide by zero** (signed or unsigned): `hi` = original `a`, `lo` = all ones, `div_by_zero` = 1.
- **Signed overflow** (MIN ÷ −1): `lo` = MIN, `hi` = 0, `div_by_zero` = 0. This needs no special casing; the magnitude path produces it.
- **MTHI/MTLO:**
  - `wr_hi`/`wr_lo` take effect on the next edge, but only while `busy == 0`. They are ignored while busy.
  - Both may be asserted together.
  - They do not touch `done` or `div_by_zero`.
  - `start` in the same cycle is still accepted; the later FIX overwrites HI/LO.
- **Ignored inputs:** `start` while busy is ignored (no queueing). Operand changes after the start edge have no effect.
- **Flush:** HI/LO and `div_by_zero` are left unchanged and no `done` is issued.

## Timing
- Start is accepted at edge k.
- `busy` is high in the cycles after edges k … k+WIDTH, i.e. WIDTH+1 cycles: WIDTH in CALC and 1 in FIX.
- At edge k+WIDTH+1:
  - `hi`/`lo` are updated.
  - `done` = 1 for exactly one cycle.
  - `busy` = 0.
- Latency from start edge to result-visible edge is WIDTH+1 edges. That is 33 edges for WIDTH = 32.
- A `start` issued in the `done` cycle is accepted, giving back-to-back operations with no idle gap.
- A flush in the FIX cycle also cancels: no HI/LO update, and `busy` = 0 next cycle.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- `hi`/`lo` only ever change on a FIX edge, an MT write edge, or reset.

## Test plan
All scenarios use WIDTH = 32.
- **Unsigned multiply with latency check:** multu 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001. `done` pulses exactly 33 edges after start, and `busy` is high for 33 cycles.
- **Signed multiply and divide, back to back:** mult −3 × 7 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB. Then div −7 ÷ 2, started in the `done` cycle → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- **Division edge cases:**
  - divu 5 ÷ 0 → `hi` = 5, `lo` = 0xFFFFFFFF, `div_by_zero` = 1.
  - Then div 0x80000000 ÷ 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0, `div_by_zero` = 0.
- **Flush behaviour:**
  - Start divu 100 ÷ 7, then assert `flush` at CALC cycle 10 → `busy` = 0 next cycle, no `done`, HI/LO hold their prior values.
  - `start` + `flush` together in IDLE → nothing is started.
- **HI/LO writes:**
  - `wr_hi` with `wdata` = 0x12345678 while idle → `hi` = 0x12345678 next cycle.
  - `wr_lo` while busy → `lo` unchanged.
  - `start` + `wr_lo` together → write applies, then is overwritten at FIX.
- **Asynchronous reset:** assert `reset` mid-CALC between clock edges → `busy`, `done`, `hi`, `lo` = 0 immediately. A new start after release completes normally.
